// File: rtl/j4_uart_pkg.sv
// Shared register map, STAT bit positions and FSM state type for the j4 UART.
package j4_uart_pkg;
  localparam int WIDTH = 16;

  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_DIV  = 2'd2;

  localparam int STAT_TX_EMPTY  = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_RX_VALID  = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_FRAME_ERR = 4;

  localparam logic [WIDTH-1:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction
endpackage

// File: rtl/j4_uart_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is kept only when a pop frees a slot on the same edge.
module j4_uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end
endmodule

// File: rtl/j4_uart.sv
// I/O-bus UART slave for the j4 core: TX byte FIFO, single RX holding register, programmable divisor.
module j4_uart
  import j4_uart_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'h8000,
  parameter logic [15:0] DEF_DIV = 16'd433,
  parameter int          TX_AW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [WIDTH-1:0] io_ptr,
  input  logic [WIDTH-1:0] io_wdata,
  output logic [WIDTH-1:0] io_rdata,
  output logic             uart_txd,
  input  logic             uart_rxd
);
  logic w_sel, w_wr_data, w_wr_stat, w_wr_div, w_rd_pop;
  logic [WIDTH-1:0] r_div;

  assign w_sel     = (io_ptr[WIDTH-1:2] == BASE[WIDTH-1:2]);
  assign w_wr_data = w_sel && io_we && (io_ptr[1:0] == UART_DATA);
  assign w_wr_stat = w_sel && io_we && (io_ptr[1:0] == UART_STAT);
  assign w_wr_div  = w_sel && io_we && (io_ptr[1:0] == UART_DIV);
  assign w_rd_pop  = w_sel && io_re && (io_ptr[1:0] == UART_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_div <= DEF_DIV;
    else if (w_wr_div) r_div <= clamp_div(io_wdata);
  end

  logic       w_fifo_pop, w_fifo_full, w_fifo_empty;
  logic [7:0] w_fifo_rdata;

  j4_uart_fifo #(.DW(8), .AW(TX_AW)) u_txfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wr_data),
    .i_wdata (io_wdata[7:0]),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  uart_state_e      r_tx_state, w_tx_state_nxt;
  logic [WIDTH-1:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
  logic [2:0]       r_tx_bit, w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_txd, w_txd_nxt, w_tx_end;

  assign w_tx_end   = (r_tx_cnt == r_tx_div);
  assign uart_txd   = r_txd;

  // STOP chains straight into the next START when the FIFO has data, so there is no idle gap.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_div_nxt   = r_tx_div;
    w_txd_nxt      = r_txd;
    w_fifo_pop     = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_txd_nxt    = 1'b1;
        if (!w_fifo_empty) begin
          w_fifo_pop     = 1'b1;
          w_tx_state_nxt = ST_START;
          w_tx_shift_nxt = w_fifo_rdata;
          w_tx_div_nxt   = r_div;
          w_txd_nxt      = 1'b0;
        end
      end
      ST_START: if (w_tx_end) begin
        w_tx_state_nxt = ST_DATA;
        w_tx_cnt_nxt   = '0;
        w_tx_bit_nxt   = '0;
        w_txd_nxt      = r_tx_shift[0];
      end
      ST_DATA: if (w_tx_end) begin
        w_tx_cnt_nxt = '0;
        if (r_tx_bit == 3'd7) begin
          w_tx_state_nxt = ST_STOP;
          w_txd_nxt      = 1'b1;
        end else begin
          w_tx_bit_nxt   = r_tx_bit + 1'b1;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_txd_nxt      = r_tx_shift[1];
        end
      end
      default: if (w_tx_end) begin
        w_tx_cnt_nxt = '0;
        if (!w_fifo_empty) begin
          w_fifo_pop     = 1'b1;
          w_tx_state_nxt = ST_START;
          w_tx_shift_nxt = w_fifo_rdata;
          w_tx_div_nxt   = r_div;
          w_txd_nxt      = 1'b0;
        end else begin
          w_tx_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift_nxt;
    r_tx_div   <= w_tx_div_nxt;
  end

  uart_state_e      r_rx_state, w_rx_state_nxt;
  logic [WIDTH-1:0] r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt, w_rx_half;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt, r_rx_byte;
  logic             r_rx_s1, r_rx_s2, r_rx_prev, w_rx_fall, w_rx_done;
  logic             r_rx_valid, r_overrun, r_frame_err;

  assign w_rx_fall = r_rx_prev && !r_rx_s2;
  assign w_rx_half = (r_rx_div >> 1) + {{(WIDTH-1){1'b0}}, r_rx_div[0]};

  // Start is re-checked half a bit after the edge so short glitches fall back to IDLE.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_div_nxt   = r_rx_div;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (w_rx_fall) begin
          w_rx_state_nxt = ST_START;
          w_rx_div_nxt   = r_div;
        end
      end
      ST_START: if (r_rx_cnt == w_rx_half) begin
        w_rx_cnt_nxt   = '0;
        w_rx_bit_nxt   = '0;
        w_rx_state_nxt = r_rx_s2 ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (r_rx_cnt == r_rx_div) begin
        w_rx_cnt_nxt   = '0;
        w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
        w_rx_bit_nxt   = r_rx_bit + 1'b1;
        if (r_rx_bit == 3'd7) w_rx_state_nxt = ST_STOP;
      end
      default: if (r_rx_cnt == r_rx_div) begin
        w_rx_done      = 1'b1;
        w_rx_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_s1    <= uart_rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift_nxt;
    r_rx_div   <= w_rx_div_nxt;
  end

  // A delivery on the same edge as a DATA pop replaces the byte instead of flagging overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_rx_done && (!r_rx_valid || w_rd_pop)) r_rx_byte <= r_rx_shift;
      if (w_rx_done)     r_rx_valid <= 1'b1;
      else if (w_rd_pop) r_rx_valid <= 1'b0;
      if (w_rx_done && r_rx_valid && !w_rd_pop)   r_overrun <= 1'b1;
      else if (w_wr_stat && io_wdata[STAT_OVERRUN]) r_overrun <= 1'b0;
      if (w_rx_done && !r_rx_s2)                  r_frame_err <= 1'b1;
      else if (w_wr_stat && io_wdata[STAT_FRAME_ERR]) r_frame_err <= 1'b0;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (w_sel) begin
      case (io_ptr[1:0])
        UART_DATA: io_rdata[7:0] = r_rx_byte;
        UART_STAT: begin
          io_rdata[STAT_TX_EMPTY]  = w_fifo_empty;
          io_rdata[STAT_TX_FULL]   = w_fifo_full;
          io_rdata[STAT_RX_VALID]  = r_rx_valid;
          io_rdata[STAT_OVERRUN]   = r_overrun;
          io_rdata[STAT_FRAME_ERR] = r_frame_err;
        end
        UART_DIV:  io_rdata = r_div;
        default:   io_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_j4_uart.sv
// Scenario bench for j4_uart: register access, TX waveform and FIFO, RX delivery, overrun, framing, glitch, reset.
module tb_j4_uart;
  localparam logic [15:0] A_DATA = 16'h8000;
  localparam logic [15:0] A_STAT = 16'h8001;
  localparam logic [15:0] A_DIV  = 16'h8002;
  localparam logic [15:0] A_RSV  = 16'h8003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_we = 1'b0;
  logic        io_re = 1'b0;
  logic [15:0] io_ptr = 16'h0;
  logic [15:0] io_wdata = 16'h0;
  logic [15:0] io_rdata;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic       tx_bit_q[$];
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;

  j4_uart dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_we    (io_we),
    .io_re    (io_re),
    .io_ptr   (io_ptr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] stat_model();
    return {11'h0, m_ferr, m_ovr, m_valid, 1'b0, 1'b1};
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_ptr = a; io_wdata = d; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic pop, output logic [15:0] d);
    @(negedge clk);
    io_ptr = a; io_re = pop;
    #1 d = io_rdata;
    @(negedge clk);
    io_re = 1'b0;
  endtask

  // Bench-side serial decoder for TX at 5 clocks per bit.
  task automatic tx_capture(input int budget, output logic found, output logic [7:0] b, output logic stop);
    int t = 0;
    found = 1'b0; b = 8'h00; stop = 1'b0;
    while (uart_txd === 1'b1 && t < budget) begin
      @(negedge clk); t++;
    end
    if (uart_txd !== 1'b0) return;
    found = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (5) @(negedge clk);
      b[i] = uart_txd;
    end
    repeat (5) @(negedge clk);
    stop = uart_txd;
  endtask

  // Drives one RX frame and updates the holding-register model.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (5) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    if (m_valid) m_ovr = 1'b1;
    else begin
      rx_exp_q.push_back(b);
      m_valid = 1'b1;
    end
    if (!stop) m_ferr = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
    bus_read(A_STAT, 1'b0, d);
    n_tests++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL reset_stat got %h exp 0001", d); end
    bus_read(A_DIV, 1'b0, d);
    n_tests++;
    if (d !== 16'd433) begin n_fail++; $display("FAIL reset_div got %0d exp 433", d); end
    bus_read(16'h4001, 1'b0, d);
    n_tests++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL unselected_read got %h exp 0000", d); end
  endtask

  task automatic test_regs();
    logic [15:0] d;
    bus_write(A_DIV, 16'd2);
    bus_read(A_DIV, 1'b0, d);
    n_tests++;
    if (d !== 16'd4) begin n_fail++; $display("FAIL div_clamp got %0d exp 4", d); end
    bus_write(A_DIV, 16'd100);
    bus_read(A_DIV, 1'b0, d);
    n_tests++;
    if (d !== 16'd100) begin n_fail++; $display("FAIL div_write got %0d exp 100", d); end
    bus_write(16'h0002, 16'd50);
    bus_read(A_DIV, 1'b0, d);
    n_tests++;
    if (d !== 16'd100) begin n_fail++; $display("FAIL div_unselected_write got %0d exp 100", d); end
    bus_write(A_RSV, 16'hFFFF);
    bus_read(A_RSV, 1'b1, d);
    n_tests++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL reserved_read got %h exp 0000", d); end
    bus_write(A_DIV, 16'd4);
  endtask

  task automatic test_tx_frame();
    logic [7:0] b;
    logic       exp;
    int         k;
    b = 8'hA5;
    tx_bit_q.delete();
    tx_bit_q.push_back(1'b1);
    repeat (5) tx_bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (5) tx_bit_q.push_back(b[i]);
    repeat (6) tx_bit_q.push_back(1'b1);
    @(negedge clk);
    io_ptr = A_DATA; io_wdata = 16'h00A5; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
    k = 0;
    while (tx_bit_q.size() > 0) begin
      exp = tx_bit_q.pop_front();
      n_tests++;
      if (uart_txd !== exp) begin
        n_fail++;
        $display("FAIL tx_wave cycle %0d got %b exp %b", k, uart_txd, exp);
      end
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_tx_fifo();
    logic [7:0]  obs_q[$];
    logic        stop_q[$];
    logic [7:0]  b;
    logic [7:0]  e;
    logic        found;
    logic        stop;
    tx_exp_q.delete();
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          io_ptr = A_DATA; io_wdata = 16'h0010 + 16'(i); io_we = 1'b1;
          if (tx_exp_q.size() < 5) tx_exp_q.push_back(8'h10 + 8'(i));
          @(negedge clk);
        end
        io_we = 1'b0; io_ptr = A_STAT;
        #1;
        n_tests++;
        if (io_rdata[1] !== 1'b1) begin n_fail++; $display("FAIL tx_full_after_5 got %b exp 1", io_rdata[1]); end
        io_ptr = A_DATA; io_wdata = 16'h0015; io_we = 1'b1;
        if (tx_exp_q.size() < 5) tx_exp_q.push_back(8'h15);
        @(negedge clk);
        io_we = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++) begin
          tx_capture(300, found, b, stop);
          if (!found) break;
          obs_q.push_back(b);
          stop_q.push_back(stop);
        end
      end
    join
    n_tests++;
    if (obs_q.size() != 5) begin n_fail++; $display("FAIL tx_frame_count got %0d exp 5", obs_q.size()); end
    while (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      stop = stop_q.pop_front();
      n_tests++;
      if (tx_exp_q.size() == 0) begin
        n_fail++; $display("FAIL tx_extra_frame got %h exp none", b);
      end else begin
        e = tx_exp_q.pop_front();
        if (b !== e || stop !== 1'b1) begin
          n_fail++; $display("FAIL tx_fifo_byte got %h stop %b exp %h stop 1", b, stop, e);
        end
      end
    end
  endtask

  task automatic read_and_check_data(input string name);
    logic [15:0] d;
    logic [7:0]  e;
    e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hXX;
    bus_read(A_DATA, 1'b1, d);
    m_valid = 1'b0;
    n_tests++;
    if (d !== {8'h00, e}) begin n_fail++; $display("FAIL %s got %h exp %h", name, d, {8'h00, e}); end
  endtask

  task automatic check_stat(input string name);
    logic [15:0] d;
    bus_read(A_STAT, 1'b0, d);
    n_tests++;
    if (d !== stat_model()) begin n_fail++; $display("FAIL %s got %h exp %h", name, d, stat_model()); end
  endtask

  task automatic test_rx_basic();
    send_rx(8'h3C, 1'b1);
    check_stat("rx_stat_valid");
    read_and_check_data("rx_data_3c");
    check_stat("rx_stat_after_pop");
  endtask

  task automatic test_rx_overrun();
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    read_and_check_data("rx_overrun_keeps_first");
    check_stat("rx_overrun_flag");
    bus_write(A_STAT, 16'h0008);
    m_ovr = 1'b0;
    check_stat("rx_overrun_clear");
  endtask

  task automatic test_rx_frame_err();
    send_rx(8'h5A, 1'b0);
    check_stat("rx_frame_err_flag");
    read_and_check_data("rx_frame_err_byte");
    bus_write(A_STAT, 16'h0010);
    m_ferr = 1'b0;
    check_stat("rx_frame_err_clear");
  endtask

  task automatic test_rx_glitch();
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (60) @(negedge clk);
    check_stat("rx_glitch_ignored");
    send_rx(8'h96, 1'b1);
    read_and_check_data("rx_after_glitch");
  endtask

  task automatic test_reset_midframe();
    logic [15:0] d;
    bus_write(A_DATA, 16'h0000);
    repeat (3) @(negedge clk);
    n_tests++;
    if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL midframe_start_bit got %b exp 0", uart_txd); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL async_reset_txd got %b exp 1", uart_txd); end
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    bus_read(A_DIV, 1'b0, d);
    n_tests++;
    if (d !== 16'd433) begin n_fail++; $display("FAIL reset_div_restored got %0d exp 433", d); end
    check_stat("reset_stat_after_abort");
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_frame();
    test_tx_fifo();
    test_rx_basic();
    test_rx_overrun();
    test_rx_frame_err();
    test_rx_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
